// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between instruction fetch (IF) and data (D) requesters.
// D has strict priority; define ARB_STARVE_GUARD_EN to bound how long IF can be denied.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  d_req,
    input  logic [3:0]            d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  en;
        logic [3:0]            we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } mem_req_t;

    state_t   state, state_nxt;
    mem_req_t mreq;
    logic     force_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [CNT_W-1:0] starve_cnt;

    // Flip priority only while IF is still asking, so D is never blocked for nothing.
    assign force_if = if_req && (starve_cnt >= CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != {CNT_W{1'b1}}) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are suppressed while reset is held so no access reaches the memory.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            if (force_if) begin
                if_gnt = if_req;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end
        end
    end

    always_comb begin
        mreq = '0;
        if (d_gnt) begin
            mreq.en   = 1'b1;
            mreq.we   = d_we;
            mreq.addr = d_addr;
            mreq.din  = d_wdata;
        end else if (if_gnt) begin
            mreq.en   = 1'b1;
            mreq.addr = if_addr;
        end
    end

    assign mem_en   = mreq.en;
    assign mem_we   = mreq.we;
    assign mem_addr = mreq.addr;
    assign mem_din  = mreq.din;

    always_comb begin
        state_nxt = IDLE;
        if (d_gnt && d_we == 4'b0000) begin
            state_nxt = D_RD;
        end else if (d_gnt) begin
            state_nxt = D_WR;
        end else if (if_gnt) begin
            state_nxt = IF_RD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign if_rvalid = (state == IF_RD);
    assign d_rvalid  = (state == D_RD);
    assign if_rdata  = if_rvalid ? mem_dout : '0;
    assign d_rdata   = d_rvalid  ? mem_dout : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a BRAM model and a read-return scoreboard.
module tb_mem_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_gnt, d_rvalid;
    logic [3:0]    d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] bram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic          is_if;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int sc    = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
            if (mem_we == 4'b0000) mem_dout <= bram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic [3:0] dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, output logic obs_ig );
        logic egd, egi, frc;
        exp_t e;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
`ifdef ARB_STARVE_GUARD_EN
        frc = ir && (sc >= LIMIT);
`else
        frc = 1'b0;
`endif
        egd = dr & ~frc;
        egi = ir & (frc | ~dr);
        if (egi || !ir) sc = 0;
        else if (sc < 7) sc = sc + 1;
        obs_igt_assign: obs_ig = if_gnt;
        chk("d_gnt", d_gnt, egd);
        chk("if_gnt", if_gnt, egi);
        chk("mem_en", mem_en, egd | egi);
        chk("mem_we", mem_we, egd ? dw : 4'h0);
        chk("mem_addr", mem_addr, egd ? da : (egi ? ia : '0));
        chk("mem_din", mem_din, egd ? dd : '0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("if_rvalid", if_rvalid, e.is_if);
            chk("d_rvalid", d_rvalid, !e.is_if);
            chk("if_rdata", if_rdata, e.is_if ? e.data : '0);
            chk("d_rdata", d_rdata, e.is_if ? '0 : e.data);
        end else begin
            chk("if_rvalid_idle", if_rvalid, 1'b0);
            chk("d_rvalid_idle", d_rvalid, 1'b0);
        end
        if (egd && dw == 4'h0) sb.push_back('{1'b0, ref_mem[da]});
        if (egd && dw != 4'h0)
            for (int b = 0; b < 4; b++)
                if (dw[b]) ref_mem[da][8*b +: 8] = dd[8*b +: 8];
        if (egi) sb.push_back('{1'b1, ref_mem[ia]});
        @(negedge clk);
    endtask

    initial begin
        logic g;
        for (int i = 0; i < (1<<AW); i++) begin
            bram[i]    = (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
            ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        end
        bram[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
        bram[14'h20] = 32'hFFFFFFFF; ref_mem[14'h20] = 32'hFFFFFFFF;
        rst = 1'b1;
        if_req = 1'b1; if_addr = '0;
        d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;

        // Reset held with a pending fetch: nothing may reach the memory.
        repeat (30) begin
            @(negedge clk); #1;
            chk("rst_mem_en", mem_en, 1'b0);
            chk("rst_if_rvalid", if_rvalid, 1'b0);
            chk("rst_d_rvalid", d_rvalid, 1'b0);
            chk("rst_if_rdata", if_rdata, '0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 14'h0, 1'b0, 4'h0, '0, '0, g);
        chk("first_if_gnt", g, 1'b1);

        // Fetch only.
        step(1'b1, 14'h10, 1'b0, 4'h0, '0, '0, g);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);

        // Conflict: D first, IF the following cycle.
        step(1'b1, 14'h4, 1'b1, 4'h0, 14'h8, '0, g);
        chk("conflict_if_stall", g, 1'b0);
        step(1'b1, 14'h4, 1'b0, 4'h0, '0, '0, g);
        chk("conflict_if_late", g, 1'b1);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);

        // Partial store then load of the same word.
        step(1'b0, 14'h0, 1'b1, 4'b0011, 14'h20, 32'h1234ABCD, g);
        step(1'b0, 14'h0, 1'b1, 4'b0000, 14'h20, '0, g);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);
        chk("store_merge_ref", ref_mem[14'h20], 32'hFFFFABCD);

        // Continuous D traffic against a waiting fetch.
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 14'h30, 1'b1, 4'h0, AW'(14'h40 + (k % 8)), '0, g);
`ifdef ARB_STARVE_GUARD_EN
            chk("starve_pattern", g, (k % (LIMIT + 1)) == LIMIT);
`else
            chk("starve_pattern", g, 1'b0);
`endif
        end
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);

        // Reset lands just before the capture edge of a granted fetch.
        if_req = 1'b1; if_addr = 14'h10;
        #1;
        chk("midrst_if_gnt", if_gnt, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt_gated", if_gnt, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_if_rvalid", if_rvalid, 1'b0);
        end
        @(negedge clk);
        if_req = 1'b0;
        rst = 1'b0;
        sc = 0;
        repeat (2) begin
            #1;
            chk("postrst_if_rvalid", if_rvalid, 1'b0);
            chk("postrst_mem_en", mem_en, 1'b0);
            @(negedge clk);
        end
        step(1'b1, 14'h10, 1'b0, 4'h0, '0, '0, g);
        step(1'b0, 14'h0, 1'b0, 4'h0, '0, '0, g);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous BRAM between two requesters of the Riscv151 core: instruction fetch (IF) and data load/store (D).
- Grants at most one access per cycle and routes read data back to the owner one cycle later.
- The grant is combinational; the owner/return path is registered.
- Sits between the fetch/memory stages and the shared instruction/data memory.

Parameters:
- ADDR_WIDTH, 14, word address width of the shared memory
- DATA_WIDTH, 32, data word width
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to win (only used with ARB_STARVE_GUARD_EN)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until granted
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until granted
- d_we  in  4  byte write enables; 0 means read
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory enable
- mem_we  out  4  memory byte write enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory read data; valid the cycle after a read with mem_en=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Arbitration (combinational, same cycle):
  - Default strict priority: D over IF.
  - d_gnt = d_req.
  - if_gnt = if_req & ~d_req.
  - Never both grants high in the same cycle.
- Memory drive:
  - mem_en = d_gnt | if_gnt.
  - mem_we = d_gnt ? d_we : 0.
  - mem_addr and mem_din come from the granted requester.
  - When nothing is granted: mem_addr = 0 and mem_din = 0.
- Return state register, states:
  - IDLE: no read outstanding.
  - IF_RD: fetch read issued last cycle.
  - D_RD: load issued last cycle.
  - D_WR: store issued last cycle.
- State transitions, each cycle:
  - next = D_RD if d_gnt and d_we == 0.
  - else D_WR if d_gnt and d_we != 0.
  - else IF_RD if if_gnt.
  - else IDLE.
- Return path:
  - if_rvalid = (state == IF_RD).
  - d_rvalid = (state == D_RD).
  - if_rdata = if_rvalid ? mem_dout : 0; d_rdata = d_rvalid ? mem_dout : 0.
  - A store produces no rvalid; its completion is the d_gnt cycle.
- Latency and throughput:
  - Read data arrives exactly 1 cycle after the grant.
  - Back-to-back grants every cycle are allowed, so full throughput is 1 access/cycle.
- Simultaneous requests: D granted, IF stalls with if_gnt=0. IF must hold if_req and if_addr.
- Request dropped before grant: legal; no access occurs and no state is kept for it.
- Reset values:
  - State = IDLE.
  - All rvalid outputs = 0, all rdata outputs = 0.
  - Starvation counter = 0.
- Reset mid-operation: a read issued in the cycle before rst asserts is discarded. No rvalid appears after rst deasserts.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A 3-bit+ saturating counter starve_cnt increments each cycle with if_req=1 and if_gnt=0.
  - It clears on if_gnt or when if_req=0.
  - When starve_cnt >= STARVE_LIMIT, priority flips for that cycle: if_gnt = if_req, d_gnt = 0. The counter then clears.
  - Effect: IF waits at most STARVE_LIMIT cycles under continuous D traffic.
- When undefined: strict D priority, no counter logic. IF can starve indefinitely under continuous D traffic.

Test Plan:
1. Reset hold 30 cycles with if_req=1 → mem_en=0, if_rvalid=0, d_rvalid=0 throughout. First cycle after release: if_gnt=1.
2. IF only: mem preloaded addr 0x10=0xDEADBEEF, if_req=1, if_addr=0x10 for 1 cycle → if_gnt=1 that cycle. Next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
3. Conflict: if_req=1 addr 0x4, d_req=1 d_we=0 addr 0x8 → cycle 0: d_gnt=1, if_gnt=0, mem_addr=0x8. Cycle 1: d_rvalid=1 with mem[0x8]; d_req low so if_gnt=1. Cycle 2: if_rvalid=1 with mem[0x4].
4. Store then load: d_we=4'b0011, d_wdata=0x1234ABCD, addr 0x20 (old 0xFFFFFFFF), then read 0x20 → no d_rvalid after store. Load returns 0xFFFFABCD.
5. Starvation, ARB_STARVE_GUARD_EN with STARVE_LIMIT=4: d_req=1 continuous, if_req=1 → if_gnt first rises on cycle 4 (0-based), then every 5th cycle. Without macro: if_gnt stays 0 for all 50 cycles.
6. Reset mid-read: grant IF read at cycle N, assert rst at N+0.5 clock → if_rvalid never asserts; state IDLE after release.
